// File: rtl/xadc_monitor.sv
// xadc_monitor: register-bus front end for the XADC DRP port.
// Runs single manual DRP accesses and a background round-robin poller.
// The poller keeps sample, min and max per channel.
// Handshake: drp_den_o is high for exactly one cycle per access, with addr/din/dwe
// valid in that cycle. The access then waits for one drp_drdy_i pulse, or gives up
// after pTIMEOUT cycles. drdy pulses are ignored in any other state.

`ifndef XADC_DRP_ADDR
`define XADC_DRP_ADDR   8'h40
`endif
`ifndef XADC_DRP_DATA
`define XADC_DRP_DATA   8'h41
`endif
`ifndef XADC_STAT
`define XADC_STAT       8'h42
`endif
`ifndef XADC_MON_CTRL
`define XADC_MON_CTRL   8'h43
`endif
`ifndef XADC_MON_SEL
`define XADC_MON_SEL    8'h44
`endif
`ifndef XADC_MON_CHADDR
`define XADC_MON_CHADDR 8'h45
`endif
`ifndef XADC_MON_DATA
`define XADC_MON_DATA   8'h46
`endif

module xadc_monitor #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pNUM_CH       = 4,
    parameter int pTIMEOUT      = 255
) (
    input  logic                     clk_usb,
    input  logic                     reset_i,
    input  logic [7:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               reg_datai,
    output logic [7:0]               reg_datao,
    input  logic                     reg_read,
    input  logic                     reg_write,
    output logic [6:0]               drp_addr_o,
    output logic [15:0]              drp_din_o,
    output logic                     drp_den_o,
    output logic                     drp_dwe_o,
    input  logic [15:0]              drp_dout_i,
    input  logic                     drp_drdy_i,
    input  logic [4:0]               alarm_i,
    output logic                     busy_o,
    output logic                     xadc_error,
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

    // Per-channel storage is sized for the 16-channel maximum; unused entries never leave reset.
    localparam int          LP_MAXCH = 16;
    localparam logic [3:0]  LP_LAST  = 4'(pNUM_CH - 1);
    localparam logic [15:0] LP_TMO   = 16'(pTIMEOUT - 1);

    state_t      r_state, w_next;
    logic        w_start_man, w_start_mon;
    logic        r_pending, r_op_write, r_cur_man, r_cur_write, r_mon_en;
    logic [6:0]  r_man_addr, r_drp_addr;
    logic [15:0] r_man_wdata, r_man_rdata, r_drp_din, r_timer;
    logic [3:0]  r_ch;
    logic [7:0]  r_sel, r_datao, w_rdata;
    logic [5:0]  r_stat;
    logic [47:0] r_snap, w_live;
    logic [6:0]  r_chaddr [LP_MAXCH];
    logic [15:0] r_sample [LP_MAXCH];
    logic [15:0] r_min    [LP_MAXCH];
    logic [15:0] r_max    [LP_MAXCH];

    logic       w_wr_addr, w_wr_data, w_wr_stat, w_wr_ctrl, w_wr_sel, w_wr_chaddr;
    logic       w_done, w_timeout, w_store, w_clr, w_sel_ok;
    logic [3:0] w_sel_idx;
    logic [2:0] w_bc;

    assign w_wr_addr   = reg_write && (reg_address == `XADC_DRP_ADDR);
    assign w_wr_data   = reg_write && (reg_address == `XADC_DRP_DATA);
    assign w_wr_stat   = reg_write && (reg_address == `XADC_STAT);
    assign w_wr_ctrl   = reg_write && (reg_address == `XADC_MON_CTRL);
    assign w_wr_sel    = reg_write && (reg_address == `XADC_MON_SEL);
    assign w_wr_chaddr = reg_write && (reg_address == `XADC_MON_CHADDR);
    assign w_clr       = w_wr_ctrl && reg_datai[1];

    assign w_done    = (r_state == S_WAIT) && drp_drdy_i;
    assign w_timeout = (r_state == S_WAIT) && !drp_drdy_i && (r_timer == LP_TMO);
    assign w_store   = w_done && !r_cur_man;

    assign w_sel_ok  = (r_sel < 8'(pNUM_CH));
    assign w_sel_idx = w_sel_ok ? r_sel[3:0] : 4'd0;
    assign w_live    = w_sel_ok ? {r_max[w_sel_idx], r_min[w_sel_idx], r_sample[w_sel_idx]} : 48'h0;
    // Byte counts above 5 collapse to code 7, which every byte mux maps to zero.
    assign w_bc      = (reg_bytecnt > pBYTECNT_SIZE'(5)) ? 3'd7 : reg_bytecnt[2:0];

    assign drp_addr_o  = r_drp_addr;
    assign drp_din_o   = r_drp_din;
    assign drp_den_o   = (r_state == S_REQ);
    assign drp_dwe_o   = (r_state == S_REQ) && r_cur_write;
    assign busy_o      = (r_state != S_IDLE) || r_pending;
    assign xadc_error  = |r_stat;
    assign reg_datao   = r_datao;
    assign dbg_state_o = r_state;

    // FSM state register.
    always_ff @(posedge clk_usb or negedge reset_i) begin
        if (!reset_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state; a pending manual request beats the poller, but only when choosing from IDLE.
    always_comb begin
        w_next      = r_state;
        w_start_man = 1'b0;
        w_start_mon = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_next      = S_REQ;
                    w_start_man = 1'b1;
                end else if (r_mon_en) begin
                    w_next      = S_REQ;
                    w_start_mon = 1'b1;
                end
            end
            S_REQ:   w_next = S_WAIT;
            S_WAIT:  if (drp_drdy_i || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Register read mux; MON_DATA bytes 1..5 come from the snapshot taken at byte 0.
    always_comb begin
        w_rdata = 8'h00;
        case (reg_address)
            `XADC_DRP_ADDR: w_rdata = {r_op_write, r_man_addr};
            `XADC_DRP_DATA: begin
                if (w_bc == 3'd0)      w_rdata = r_man_rdata[7:0];
                else if (w_bc == 3'd1) w_rdata = r_man_rdata[15:8];
            end
            `XADC_STAT:       w_rdata = {1'b0, r_pending, r_stat};
            `XADC_MON_CTRL:   w_rdata = {7'b0, r_mon_en};
            `XADC_MON_SEL:    w_rdata = r_sel;
            `XADC_MON_CHADDR: w_rdata = w_sel_ok ? {1'b0, r_chaddr[w_sel_idx]} : 8'h00;
            `XADC_MON_DATA: begin
                case (w_bc)
                    3'd0:    w_rdata = w_live[7:0];
                    3'd1:    w_rdata = r_snap[15:8];
                    3'd2:    w_rdata = r_snap[23:16];
                    3'd3:    w_rdata = r_snap[31:24];
                    3'd4:    w_rdata = r_snap[39:32];
                    3'd5:    w_rdata = r_snap[47:40];
                    default: w_rdata = 8'h00;
                endcase
            end
            default: w_rdata = 8'h00;
        endcase
    end

    // Control registers, manual request, DRP launch, status and read-back.
    always_ff @(posedge clk_usb or negedge reset_i) begin
        if (!reset_i) begin
            r_pending   <= 1'b0;
            r_op_write  <= 1'b0;
            r_man_addr  <= 7'h0;
            r_man_wdata <= 16'h0;
            r_man_rdata <= 16'h0;
            r_cur_man   <= 1'b0;
            r_cur_write <= 1'b0;
            r_drp_addr  <= 7'h0;
            r_drp_din   <= 16'h0;
            r_timer     <= 16'h0;
            r_mon_en    <= 1'b0;
            r_sel       <= 8'h0;
            r_stat      <= 6'h0;
            r_datao     <= 8'h0;
            r_snap      <= 48'h0;
        end else begin
            // A new DRP_ADDR write replaces any request still waiting to be issued.
            if (w_wr_addr) begin
                r_man_addr <= reg_datai[6:0];
                r_op_write <= reg_datai[7];
                r_pending  <= 1'b1;
            end else if (r_cur_man && (w_done || w_timeout)) begin
                r_pending  <= 1'b0;
            end
            if (w_wr_data && w_bc == 3'd0) r_man_wdata[7:0]  <= reg_datai;
            if (w_wr_data && w_bc == 3'd1) r_man_wdata[15:8] <= reg_datai;
            if (w_done && r_cur_man && !r_cur_write) r_man_rdata <= drp_dout_i;

            if (w_start_man) begin
                r_cur_man   <= 1'b1;
                r_cur_write <= r_op_write;
                r_drp_addr  <= r_man_addr;
                r_drp_din   <= r_man_wdata;
            end else if (w_start_mon) begin
                r_cur_man   <= 1'b0;
                r_cur_write <= 1'b0;
                r_drp_addr  <= r_chaddr[r_ch];
                r_drp_din   <= 16'h0;
            end
            r_timer <= (r_state == S_WAIT) ? r_timer + 16'd1 : 16'h0;

            if (w_wr_ctrl) r_mon_en <= reg_datai[0];
            if (w_wr_sel)  r_sel    <= reg_datai;
            // Alarm/timeout sets win over a same-cycle write-1-to-clear.
            r_stat <= (r_stat & ~(w_wr_stat ? reg_datai[5:0] : 6'h0)) | {w_timeout, alarm_i};

            r_datao <= reg_read ? w_rdata : 8'h00;
            if (reg_read && reg_address == `XADC_MON_DATA && w_bc == 3'd0) r_snap <= w_live;
        end
    end

    // Poller channel storage; a clear landing with a store leaves that channel at min=max=sample.
    always_ff @(posedge clk_usb or negedge reset_i) begin
        if (!reset_i) begin
            r_ch <= 4'd0;
            for (int i = 0; i < LP_MAXCH; i++) begin
                r_chaddr[i] <= 7'h0;
                r_sample[i] <= 16'h0;
                r_min[i]    <= 16'hFFFF;
                r_max[i]    <= 16'h0000;
            end
        end else begin
            if (w_store) r_ch <= (r_ch == LP_LAST) ? 4'd0 : r_ch + 4'd1;
            for (int i = 0; i < LP_MAXCH; i++) begin
                if (w_wr_chaddr && w_sel_ok && r_sel[3:0] == 4'(i)) r_chaddr[i] <= reg_datai[6:0];
                if (w_store && r_ch == 4'(i)) begin
                    r_sample[i] <= drp_dout_i;
                    if (w_clr || drp_dout_i < r_min[i]) r_min[i] <= drp_dout_i;
                    if (w_clr || drp_dout_i > r_max[i]) r_max[i] <= drp_dout_i;
                end else if (w_clr) begin
                    r_min[i] <= 16'hFFFF;
                    r_max[i] <= 16'h0000;
                end
            end
        end
    end

endmodule

// File: tb/tb_xadc_monitor.sv
// Directed bench for xadc_monitor: manual DRP read/write, round-robin polling,
// manual-over-poll ordering, timeout and alarm status, reset during a transaction.
module tb_xadc_monitor;

  localparam logic [7:0] A_DRP_ADDR   = 8'h40;
  localparam logic [7:0] A_DRP_DATA   = 8'h41;
  localparam logic [7:0] A_STAT       = 8'h42;
  localparam logic [7:0] A_MON_CTRL   = 8'h43;
  localparam logic [7:0] A_MON_SEL    = 8'h44;
  localparam logic [7:0] A_MON_CHADDR = 8'h45;
  localparam logic [7:0] A_MON_DATA   = 8'h46;

  logic        clk_usb = 1'b0;
  logic        reset_i = 1'b0;
  logic [7:0]  reg_address = 8'h0;
  logic [6:0]  reg_bytecnt = 7'h0;
  logic [7:0]  reg_datai = 8'h0;
  logic [7:0]  reg_datao;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic [6:0]  drp_addr_o;
  logic [15:0] drp_din_o;
  logic        drp_den_o, drp_dwe_o;
  logic [15:0] drp_dout_i = 16'h0;
  logic        drp_drdy_i = 1'b0;
  logic [4:0]  alarm_i = 5'h0;
  logic        busy_o, xadc_error;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  // DRP slave model state
  logic [15:0] mem [128];
  logic [15:0] ch0_q [$];
  logic [6:0]  addr_log [$];
  logic        we_log [$];
  logic [15:0] din_log [$];
  bit          resp_en = 1'b1;
  int          resp_lat = 3;

  xadc_monitor #(.pBYTECNT_SIZE(7), .pNUM_CH(4), .pTIMEOUT(255)) dut (
    .clk_usb(clk_usb), .reset_i(reset_i),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai),
    .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write),
    .drp_addr_o(drp_addr_o), .drp_din_o(drp_din_o), .drp_den_o(drp_den_o),
    .drp_dwe_o(drp_dwe_o), .drp_dout_i(drp_dout_i), .drp_drdy_i(drp_drdy_i),
    .alarm_i(alarm_i), .busy_o(busy_o), .xadc_error(xadc_error), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_usb = ~clk_usb;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic reg_wr(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
    @(negedge clk_usb);
    reg_address = a; reg_bytecnt = bc; reg_datai = d; reg_write = 1'b1;
    @(negedge clk_usb);
    reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, input logic [6:0] bc, output logic [7:0] d);
    @(negedge clk_usb);
    reg_address = a; reg_bytecnt = bc; reg_read = 1'b1;
    @(negedge clk_usb);
    reg_read = 1'b0;
    d = reg_datao;
  endtask

  task automatic mon_rd(input logic [7:0] sel, output logic [47:0] v);
    logic [7:0] b;
    reg_wr(A_MON_SEL, 7'd0, sel);
    for (int k = 0; k < 6; k++) begin
      reg_rd(A_MON_DATA, 7'(k), b);
      v[k*8 +: 8] = b;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk_usb);
      n++;
    end
    check_val(tag, {63'b0, busy_o}, 64'd0);
  endtask

  task automatic wait_log(input int cnt, input int budget);
    int n;
    n = 0;
    while (addr_log.size() < cnt && n < budget) begin
      @(negedge clk_usb);
      n++;
    end
    check_val("log_count", 64'(addr_log.size() >= cnt), 64'd1);
  endtask

  // DRP slave: sees den at negedge, answers drdy after resp_lat cycles
  initial begin
    logic [6:0]  a;
    logic [15:0] v;
    forever begin
      @(negedge clk_usb);
      if (drp_den_o && resp_en) begin
        a = drp_addr_o;
        addr_log.push_back(a);
        we_log.push_back(drp_dwe_o);
        din_log.push_back(drp_din_o);
        if (drp_dwe_o) mem[a] = drp_din_o;
        if (a == 7'h0 && ch0_q.size() > 0) v = ch0_q.pop_front();
        else v = mem[a];
        @(negedge clk_usb);
        check_val("den_one_cycle", {63'b0, drp_den_o}, 64'd0);
        repeat (resp_lat - 2) @(negedge clk_usb);
        drp_dout_i = v;
        drp_drdy_i = 1'b1;
        @(negedge clk_usb);
        drp_drdy_i = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0]  b;
    logic [47:0] m;
    int          n;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;

    repeat (3) @(negedge clk_usb);
    // reset state
    check_val("rst_den", {63'b0, drp_den_o}, 64'd0);
    check_val("rst_dwe", {63'b0, drp_dwe_o}, 64'd0);
    check_val("rst_addr", {57'b0, drp_addr_o}, 64'd0);
    check_val("rst_din", {48'b0, drp_din_o}, 64'd0);
    check_val("rst_busy", {63'b0, busy_o}, 64'd0);
    check_val("rst_err", {63'b0, xadc_error}, 64'd0);
    check_val("rst_datao", {56'b0, reg_datao}, 64'd0);
    reset_i = 1'b1;
    @(negedge clk_usb);
    reg_rd(A_STAT, 7'd0, b);
    check_val("rst_stat", {56'b0, b}, 64'h0);
    mon_rd(8'd0, m);
    check_val("rst_mon0", {16'b0, m}, 64'h0000_FFFF_0000);

    // manual read
    mem[0] = 16'h9ABC;
    reg_wr(A_DRP_ADDR, 7'd0, 8'h00);
    wait_idle("idle_mread", 50);
    check_val("mread_addr", {57'b0, addr_log[0]}, 64'h00);
    check_val("mread_we", {63'b0, we_log[0]}, 64'd0);
    reg_rd(A_DRP_DATA, 7'd0, b);
    check_val("mread_b0", {56'b0, b}, 64'hBC);
    reg_rd(A_DRP_DATA, 7'd1, b);
    check_val("mread_b1", {56'b0, b}, 64'h9A);
    reg_rd(A_DRP_DATA, 7'd2, b);
    check_val("mread_b2", {56'b0, b}, 64'h00);

    // manual write
    addr_log.delete(); we_log.delete(); din_log.delete();
    reg_wr(A_DRP_DATA, 7'd0, 8'h34);
    reg_wr(A_DRP_DATA, 7'd1, 8'h12);
    reg_wr(A_DRP_ADDR, 7'd0, 8'hC1);
    check_val("mwrite_busy", {63'b0, busy_o}, 64'd1);
    wait_idle("idle_mwrite", 50);
    check_val("mwrite_addr", {57'b0, addr_log[0]}, 64'h41);
    check_val("mwrite_we", {63'b0, we_log[0]}, 64'd1);
    check_val("mwrite_din", {48'b0, din_log[0]}, 64'h1234);
    reg_rd(A_DRP_DATA, 7'd0, b);
    check_val("mwrite_keep_rd", {56'b0, b}, 64'hBC);

    // monitor channel addresses
    reg_wr(A_MON_SEL, 7'd0, 8'd0); reg_wr(A_MON_CHADDR, 7'd0, 8'h00);
    reg_wr(A_MON_SEL, 7'd0, 8'd1); reg_wr(A_MON_CHADDR, 7'd0, 8'h01);
    reg_wr(A_MON_SEL, 7'd0, 8'd2); reg_wr(A_MON_CHADDR, 7'd0, 8'h02);
    reg_wr(A_MON_SEL, 7'd0, 8'd3); reg_wr(A_MON_CHADDR, 7'd0, 8'h06);
    reg_rd(A_MON_CHADDR, 7'd0, b);
    check_val("chaddr3", {56'b0, b}, 64'h06);
    reg_wr(A_MON_SEL, 7'd0, 8'd5); reg_wr(A_MON_CHADDR, 7'd0, 8'h33);
    reg_rd(A_MON_CHADDR, 7'd0, b);
    check_val("chaddr_oob", {56'b0, b}, 64'h00);

    // polling: three rounds land on ch0
    addr_log.delete(); we_log.delete(); din_log.delete();
    ch0_q.push_back(16'h0100); ch0_q.push_back(16'h0300); ch0_q.push_back(16'h0200);
    mem[1] = 16'h0050; mem[2] = 16'h0060; mem[6] = 16'h0070;
    reg_wr(A_MON_CTRL, 7'd0, 8'h01);
    wait_log(9, 200);
    reg_wr(A_MON_CTRL, 7'd0, 8'h00);
    wait_idle("idle_poll", 50);
    check_val("poll_order0", {57'b0, addr_log[0]}, 64'h00);
    check_val("poll_order1", {57'b0, addr_log[1]}, 64'h01);
    check_val("poll_order2", {57'b0, addr_log[2]}, 64'h02);
    check_val("poll_order3", {57'b0, addr_log[3]}, 64'h06);
    check_val("poll_order4", {57'b0, addr_log[4]}, 64'h00);
    check_val("poll_count", 64'(addr_log.size()), 64'd9);
    mon_rd(8'd0, m);
    check_val("mon_ch0", {16'b0, m}, 64'h0300_0100_0200);
    mon_rd(8'd3, m);
    check_val("mon_ch3", {16'b0, m}, 64'h0070_0070_0070);

    // manual request arriving while a poll is waiting
    addr_log.delete(); we_log.delete(); din_log.delete();
    mem[7'h10] = 16'h5555;
    resp_lat = 6;
    reg_wr(A_MON_CTRL, 7'd0, 8'h01);
    wait_log(1, 100);
    reg_wr(A_DRP_ADDR, 7'd0, 8'h10);
    wait_log(3, 100);
    reg_wr(A_MON_CTRL, 7'd0, 8'h00);
    wait_idle("idle_prio", 50);
    check_val("prio_poll", {57'b0, addr_log[0]}, 64'h01);
    check_val("prio_man", {57'b0, addr_log[1]}, 64'h10);
    check_val("prio_resume", {57'b0, addr_log[2]}, 64'h02);
    reg_rd(A_DRP_DATA, 7'd0, b);
    check_val("prio_data", {56'b0, b}, 64'h55);

    // min/max clear
    reg_wr(A_MON_CTRL, 7'd0, 8'h02);
    reg_rd(A_MON_CTRL, 7'd0, b);
    check_val("ctrl_rd", {56'b0, b}, 64'h00);
    mon_rd(8'd0, m);
    check_val("mon_clr", {16'b0, m}, 64'h0000_FFFF_0200);
    reg_rd(A_MON_DATA, 7'd6, b);
    check_val("mon_bc6", {56'b0, b}, 64'h00);

    // timeout
    resp_en = 1'b0;
    reg_wr(A_DRP_ADDR, 7'd0, 8'h05);
    n = 0;
    while (!xadc_error && n < 400) begin
      @(negedge clk_usb);
      n++;
    end
    check_val("tmo_err", {63'b0, xadc_error}, 64'd1);
    check_val("tmo_window", 64'(n >= 250 && n <= 262), 64'd1);
    reg_rd(A_STAT, 7'd0, b);
    check_val("tmo_stat", {56'b0, b}, 64'h20);
    check_val("tmo_busy", {63'b0, busy_o}, 64'd0);
    reg_rd(A_DRP_DATA, 7'd1, b);
    check_val("tmo_keep", {56'b0, b}, 64'h55);
    reg_wr(A_STAT, 7'd0, 8'h20);
    reg_rd(A_STAT, 7'd0, b);
    check_val("stat_w1c", {56'b0, b}, 64'h00);
    check_val("err_clr", {63'b0, xadc_error}, 64'd0);
    @(negedge clk_usb); alarm_i = 5'h01;
    @(negedge clk_usb); alarm_i = 5'h00;
    repeat (3) @(negedge clk_usb);
    reg_rd(A_STAT, 7'd0, b);
    check_val("alarm_sticky", {56'b0, b}, 64'h01);
    check_val("alarm_err", {63'b0, xadc_error}, 64'd1);
    reg_wr(A_STAT, 7'd0, 8'h01);

    // reset during WAIT, drdy arrives after release
    resp_en = 1'b1;
    resp_lat = 20;
    reg_wr(A_DRP_ADDR, 7'd0, 8'h00);
    repeat (6) @(negedge clk_usb);
    check_val("pre_rst_wait", {62'b0, dbg_state_o}, 64'd2);
    reset_i = 1'b0;
    #1;
    check_val("arst_busy", {63'b0, busy_o}, 64'd0);
    check_val("arst_den", {63'b0, drp_den_o}, 64'd0);
    check_val("arst_addr", {57'b0, drp_addr_o}, 64'd0);
    check_val("arst_din", {48'b0, drp_din_o}, 64'd0);
    check_val("arst_err", {63'b0, xadc_error}, 64'd0);
    repeat (2) @(negedge clk_usb);
    reset_i = 1'b1;
    repeat (25) @(negedge clk_usb);
    check_val("late_drdy_busy", {63'b0, busy_o}, 64'd0);
    reg_rd(A_DRP_DATA, 7'd0, b);
    check_val("late_drdy_data", {56'b0, b}, 64'h00);
    mon_rd(8'd0, m);
    check_val("arst_mon0", {16'b0, m}, 64'h0000_FFFF_0000);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
